// File: rtl/fe_pkg.sv
// rtl/fe_pkg.sv - shared front-end constants and helpers for the warp fetch scheduler
package fe_pkg;

    localparam int unsigned PC_INC = 4;

    // Loaded PCs are word aligned; bits [1:0] are always cleared.
    localparam logic [63:0] PC_ALIGN_MASK = ~64'h3;

    function automatic int wid_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_multi_grant_arb.sv
// rtl/rr_multi_grant_arb.sv - combinational rotating-priority arbiter granting up to GRANTS requesters
module rr_multi_grant_arb
    import fe_pkg::*;
#(
    parameter int NUM_WARPS = 8,
    parameter int GRANTS    = 2,
    parameter int WID_W     = wid_width(NUM_WARPS)
) (
    input  logic [NUM_WARPS-1:0]    elig,
    input  logic [WID_W-1:0]        ptr,
    output logic [GRANTS-1:0]       gnt_valid,
    output logic [GRANTS*WID_W-1:0] gnt_wid_flat,
    output logic [WID_W-1:0]        ptr_next
);

    logic [WID_W-1:0] idx;
    int               cnt;

    // Scan from ptr; slots fill in scan order so granted slots are always packed low.
    always_comb begin
        gnt_valid    = '0;
        gnt_wid_flat = '0;
        ptr_next     = ptr;
        idx          = '0;
        cnt          = 0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            idx = WID_W'((int'(ptr) + i) % NUM_WARPS);
            if (elig[idx] && (cnt < GRANTS)) begin
                for (int g = 0; g < GRANTS; g++) begin
                    if (cnt == g) begin
                        gnt_valid[g]                   = 1'b1;
                        gnt_wid_flat[g*WID_W +: WID_W] = idx;
                    end
                end
                cnt      = cnt + 1;
                ptr_next = WID_W'((int'(idx) + 1) % NUM_WARPS);
            end
        end
    end

endmodule

// File: rtl/warp_fetch_sched.sv
// rtl/warp_fetch_sched.sv - per-warp PC state and registered multi-slot fetch scheduling
module warp_fetch_sched
    import fe_pkg::*;
#(
    parameter int NUM_WARPS = 8,
    parameter int GRANTS    = 2,
    parameter int ADDR_W    = 32,
    parameter int WID_W     = wid_width(NUM_WARPS)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start_valid,
    input  logic [WID_W-1:0]            start_wid,
    input  logic [ADDR_W-1:0]           start_pc,
    input  logic [NUM_WARPS-1:0]        req,
    input  logic [NUM_WARPS-1:0]        stall,
    input  logic [NUM_WARPS-1:0]        redir_valid,
    input  logic [NUM_WARPS*ADDR_W-1:0] redir_pc_flat,
    input  logic [NUM_WARPS-1:0]        exit_valid,
    output logic [GRANTS-1:0]           fetch_valid,
    output logic [GRANTS*WID_W-1:0]     fetch_wid_flat,
    output logic [GRANTS*ADDR_W-1:0]    fetch_pc_flat,
    output logic [GRANTS-1:0]           fetch_kill,
    output logic [NUM_WARPS-1:0]        active
);

    logic [ADDR_W-1:0]        pc_q [NUM_WARPS];
    logic [ADDR_W-1:0]        pc_d [NUM_WARPS];
    logic [NUM_WARPS-1:0]     active_q, active_d;
    logic [WID_W-1:0]         ptr_q, ptr_d;
    logic [GRANTS-1:0]        fv_q, fv_d;
    logic [GRANTS*WID_W-1:0]  fwid_q, fwid_d;
    logic [GRANTS*ADDR_W-1:0] fpc_q, fpc_d;

    logic [NUM_WARPS-1:0]     start_hit;
    logic [NUM_WARPS-1:0]     inflight;
    logic [NUM_WARPS-1:0]     elig;
    logic [NUM_WARPS-1:0]     granted;
    logic [GRANTS-1:0]        gnt_valid;
    logic [GRANTS*WID_W-1:0]  gnt_wid_flat;
    logic [WID_W-1:0]         ptr_next;

    always_comb begin
        start_hit = '0;
        inflight  = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            start_hit[w] = start_valid && (start_wid == WID_W'(w));
            for (int g = 0; g < GRANTS; g++) begin
                if (fv_q[g] && (fwid_q[g*WID_W +: WID_W] == WID_W'(w)))
                    inflight[w] = 1'b1;
            end
        end
    end

    assign elig = active_q & req & ~stall & ~redir_valid & ~exit_valid & ~inflight & ~start_hit;

    rr_multi_grant_arb #(
        .NUM_WARPS (NUM_WARPS),
        .GRANTS    (GRANTS),
        .WID_W     (WID_W)
    ) u_arb (
        .elig         (elig),
        .ptr          (ptr_q),
        .gnt_valid    (gnt_valid),
        .gnt_wid_flat (gnt_wid_flat),
        .ptr_next     (ptr_next)
    );

    always_comb begin
        granted = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            for (int g = 0; g < GRANTS; g++) begin
                if (gnt_valid[g] && (gnt_wid_flat[g*WID_W +: WID_W] == WID_W'(w)))
                    granted[w] = 1'b1;
            end
        end
    end

    // Start beats exit and redirect; redirect only lands on an active warp.
    always_comb begin
        active_d = active_q;
        for (int w = 0; w < NUM_WARPS; w++) begin
            pc_d[w] = pc_q[w];
            if (start_hit[w]) begin
                pc_d[w]     = start_pc & PC_ALIGN_MASK[ADDR_W-1:0];
                active_d[w] = 1'b1;
            end else begin
                if (redir_valid[w] && active_q[w])
                    pc_d[w] = redir_pc_flat[w*ADDR_W +: ADDR_W] & PC_ALIGN_MASK[ADDR_W-1:0];
                else if (granted[w])
                    pc_d[w] = pc_q[w] + ADDR_W'(PC_INC);
                if (exit_valid[w])
                    active_d[w] = 1'b0;
            end
        end
    end

    always_comb begin
        fv_d   = gnt_valid;
        fwid_d = gnt_wid_flat;
        fpc_d  = '0;
        ptr_d  = ptr_next;
        for (int g = 0; g < GRANTS; g++) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                if (gnt_valid[g] && (gnt_wid_flat[g*WID_W +: WID_W] == WID_W'(w)))
                    fpc_d[g*ADDR_W +: ADDR_W] = pc_q[w];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int w = 0; w < NUM_WARPS; w++)
                pc_q[w] <= '0;
            active_q <= '0;
            ptr_q    <= '0;
            fv_q     <= '0;
            fwid_q   <= '0;
            fpc_q    <= '0;
        end else begin
            for (int w = 0; w < NUM_WARPS; w++)
                pc_q[w] <= pc_d[w];
            active_q <= active_d;
            ptr_q    <= ptr_d;
            fv_q     <= fv_d;
            fwid_q   <= fwid_d;
            fpc_q    <= fpc_d;
        end
    end

    // A slot whose warp is redirected, exits or restarts this cycle carries a stale PC.
    always_comb begin
        fetch_kill = '0;
        for (int g = 0; g < GRANTS; g++) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                if (fv_q[g] && (fwid_q[g*WID_W +: WID_W] == WID_W'(w)) &&
                    (redir_valid[w] || exit_valid[w] || start_hit[w]))
                    fetch_kill[g] = 1'b1;
            end
        end
    end

    assign fetch_valid    = fv_q;
    assign fetch_wid_flat = fwid_q;
    assign fetch_pc_flat  = fpc_q;
    assign active         = active_q;

endmodule

// File: tb/tb_warp_fetch_sched.sv
// tb/tb_warp_fetch_sched.sv - directed self-checking bench for warp_fetch_sched
module tb_warp_fetch_sched;

    localparam int NW = 8;
    localparam int G  = 2;
    localparam int AW = 32;
    localparam int WW = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start_valid;
    logic [WW-1:0]    start_wid;
    logic [AW-1:0]    start_pc;
    logic [NW-1:0]    req;
    logic [NW-1:0]    stall;
    logic [NW-1:0]    redir_valid;
    logic [NW*AW-1:0] redir_pc_flat;
    logic [NW-1:0]    exit_valid;
    logic [G-1:0]     fetch_valid;
    logic [G*WW-1:0]  fetch_wid_flat;
    logic [G*AW-1:0]  fetch_pc_flat;
    logic [G-1:0]     fetch_kill;
    logic [NW-1:0]    active;

    int checks   = 0;
    int failures = 0;

    warp_fetch_sched #(
        .NUM_WARPS (NW),
        .GRANTS    (G),
        .ADDR_W    (AW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_valid    (start_valid),
        .start_wid      (start_wid),
        .start_pc       (start_pc),
        .req            (req),
        .stall          (stall),
        .redir_valid    (redir_valid),
        .redir_pc_flat  (redir_pc_flat),
        .exit_valid     (exit_valid),
        .fetch_valid    (fetch_valid),
        .fetch_wid_flat (fetch_wid_flat),
        .fetch_pc_flat  (fetch_pc_flat),
        .fetch_kill     (fetch_kill),
        .active         (active)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_start(input int w, input logic [AW-1:0] pc);
        start_valid = 1'b1;
        start_wid   = WW'(w);
        start_pc    = pc;
    endtask

    task automatic clear_ctl();
        start_valid = 1'b0;
        redir_valid = '0;
        exit_valid  = '0;
    endtask

    task automatic chk_slot(input string tag, input int g, input int w, input logic [AW-1:0] pc);
        check({tag, "_v"},   64'(fetch_valid[g]), 64'd1);
        check({tag, "_wid"}, 64'(fetch_wid_flat[g*WW +: WW]), 64'(w));
        check({tag, "_pc"},  64'(fetch_pc_flat[g*AW +: AW]), 64'(pc));
    endtask

    initial begin
        rst_n         = 1'b0;
        start_valid   = 1'b0;
        start_wid     = '0;
        start_pc      = '0;
        req           = '0;
        stall         = '0;
        redir_valid   = '0;
        redir_pc_flat = '0;
        exit_valid    = '0;

        repeat (2) tick();
        settle();
        check("rst_valid", 64'(fetch_valid), 64'd0);
        check("rst_active", 64'(active), 64'd0);
        check("rst_kill", 64'(fetch_kill), 64'd0);
        check("rst_pc", 64'(fetch_pc_flat), 64'd0);
        tick();
        rst_n = 1'b1;

        // single launch
        tick(); req = '1; do_start(3, 32'h100); settle();
        tick(); clear_ctl(); settle();
        check("launch_t1_valid", 64'(fetch_valid), 64'd0);
        check("launch_active", 64'(active), 64'h08);
        tick(); settle();
        check("launch_t2_slots", 64'(fetch_valid), 64'b01);
        chk_slot("launch_t2", 0, 3, 32'h100);
        tick(); settle();
        check("launch_t3_valid", 64'(fetch_valid), 64'd0);
        tick(); settle();
        chk_slot("launch_t4", 0, 3, 32'h104);
        exit_valid = 8'h08; settle();
        check("exit3_kill", 64'(fetch_kill), 64'b01);
        tick(); clear_ctl(); settle();
        check("exit3_active", 64'(active), 64'd0);
        check("exit3_valid0", 64'(fetch_valid), 64'd0);
        tick(); settle();
        check("exit3_valid1", 64'(fetch_valid), 64'd0);

        // redirect kill
        tick(); do_start(2, 32'h300); settle();
        tick(); clear_ctl(); settle();
        tick(); settle();
        chk_slot("redir_pre", 0, 2, 32'h300);
        redir_valid = 8'h04;
        redir_pc_flat[2*AW +: AW] = 32'h403;
        settle();
        check("redir_kill", 64'(fetch_kill), 64'b01);
        tick(); clear_ctl(); settle();
        check("redir_gap", 64'(fetch_valid), 64'd0);
        tick(); settle();
        chk_slot("redir_post", 0, 2, 32'h400);
        exit_valid = 8'h04;

        // stall
        tick(); clear_ctl(); stall = 8'h01; do_start(0, 32'h500); settle();
        for (int i = 0; i < 6; i++) begin
            tick(); clear_ctl(); settle();
            check($sformatf("stall_c%0d", i), 64'(fetch_valid), 64'd0);
        end
        stall = '0;
        tick(); settle();
        chk_slot("stall_rel", 0, 0, 32'h500);
        exit_valid = 8'h01;
        tick(); clear_ctl(); settle();

        // exit and start on the same warp in the same cycle
        do_start(5, 32'h600); settle();
        tick(); clear_ctl(); settle();
        tick(); settle();
        chk_slot("es_pre", 0, 5, 32'h600);
        exit_valid = 8'h20;
        do_start(5, 32'h203);
        settle();
        check("es_kill", 64'(fetch_kill), 64'b01);
        tick(); clear_ctl(); settle();
        check("es_active", 64'(active), 64'h20);
        check("es_gap", 64'(fetch_valid), 64'd0);
        tick(); settle();
        chk_slot("es_post", 0, 5, 32'h200);
        exit_valid = 8'h20; settle();
        check("exit5_kill", 64'(fetch_kill), 64'b01);
        tick(); clear_ctl(); settle();
        check("exit5_active", 64'(active), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick(); settle();
            check($sformatf("exit5_idle%0d", i), 64'(fetch_valid), 64'd0);
        end

        // asynchronous reset between edges
        tick(); do_start(1, 32'h700); settle();
        tick(); clear_ctl(); settle();
        tick(); settle();
        chk_slot("arst_pre", 0, 1, 32'h700);
        #1 rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(fetch_valid), 64'd0);
        check("arst_active", 64'(active), 64'd0);
        check("arst_wid", 64'(fetch_wid_flat), 64'd0);
        check("arst_pc", 64'(fetch_pc_flat), 64'd0);
        tick(); rst_n = 1'b1; settle();
        for (int i = 0; i < 3; i++) begin
            tick(); settle();
            check($sformatf("arst_idle%0d", i), 64'(fetch_valid), 64'd0);
        end

        // full rotation over eight warps
        req = '0;
        for (int w = 0; w < NW; w++) begin
            tick(); do_start(w, 32'h1000 + 32'(w) * 32'h100); settle();
        end
        tick(); clear_ctl(); req = '1; settle();
        check("rot_active", 64'(active), 64'hff);
        check("rot_idle", 64'(fetch_valid), 64'd0);
        for (int k = 0; k < 5; k++) begin
            int w0;
            int w1;
            logic [AW-1:0] adv;
            w0  = (2 * k) % NW;
            w1  = (2 * k + 1) % NW;
            adv = (k >= 4) ? 32'h4 : 32'h0;
            tick(); settle();
            chk_slot($sformatf("rot%0d_s0", k), 0, w0, 32'h1000 + 32'(w0) * 32'h100 + adv);
            chk_slot($sformatf("rot%0d_s1", k), 1, w1, 32'h1000 + 32'(w1) * 32'h100 + adv);
        end

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
